// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/execute sequencer for the 9-bit SPORK core.
// Owns the PC and instruction register, handshakes with instruction and data memory,
// and turns decoder strobes into one-cycle-per-instruction register/memory strobes.
// Optional feature macro: SEQ_PERF_CNT_EN adds cycle_cnt/instr_cnt performance counters.
module instr_sequencer #(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned OFF_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [PC_W-1:0]   pc,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic [8:0]        instr_in,
    output logic [8:0]        instruction,
    input  logic              halt,
    input  logic              branch,
    input  logic              branch_taken,
    input  logic [OFF_W-1:0]  branch_offset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              reg_write,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ack,
    output logic              rf_we,
    output logic              done
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [15:0]       cycle_cnt,
    output logic [15:0]       instr_cnt
`endif
);

    localparam int unsigned INSTR_W = 9;
    localparam int unsigned EXT_W   = (PC_W > OFF_W) ? PC_W : OFF_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALTED
    } state_t;

    state_t               state;
    state_t               state_d;
    logic [PC_W-1:0]      pc_d;
    logic [INSTR_W-1:0]   instr_d;
    logic                 imem_req_d;
    logic                 dmem_req_d;
    logic                 dmem_we_d;
    logic                 rf_we_d;
    logic [EXT_W-1:0]     off_ext;
    logic [PC_W-1:0]      pc_branch;
    logic [PC_W-1:0]      pc_incr;

    // Sign-extend the branch offset; PC arithmetic wraps modulo 2**PC_W.
    assign off_ext   = EXT_W'($signed(branch_offset));
    assign pc_branch = pc + off_ext[PC_W-1:0];
    assign pc_incr   = pc + PC_W'(1);

    // DONE is decoded directly from the state.
    assign done = (state == S_HALTED);

    // State and output registers; reset aborts any state in one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= PC_W'(RESET_PC);
            instruction <= '0;
            imem_req    <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            rf_we       <= 1'b0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            instruction <= instr_d;
            imem_req    <= imem_req_d;
            dmem_req    <= dmem_req_d;
            dmem_we     <= dmem_we_d;
            rf_we       <= rf_we_d;
        end
    end

    // Next-state, PC/IR update and next values of the registered strobes.
    always_comb begin
        state_d   = state;
        pc_d      = pc;
        instr_d   = instruction;
        dmem_we_d = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = PC_W'(RESET_PC);
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = instr_in;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = halt ? S_HALTED : S_EXEC;
            end
            S_EXEC: begin
                dmem_we_d = mem_write;
                if (mem_read || mem_write) begin
                    state_d = S_MEM;
                end else if (reg_write) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
                pc_d = (branch && branch_taken) ? pc_branch : pc_incr;
            end
            S_MEM: begin
                // dmem_we holds the store qualifier latched at EXEC exit.
                if (dmem_ack) begin
                    state_d = dmem_we ? S_FETCH : S_WB;
                end else begin
                    dmem_we_d = dmem_we;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
            end
            S_HALTED: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = PC_W'(RESET_PC);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        imem_req_d = (state_d == S_FETCH);
        dmem_req_d = (state_d == S_MEM);
        rf_we_d    = (state_d == S_WB);
    end

`ifdef SEQ_PERF_CNT_EN
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic start_acc;
    logic active;

    assign start_acc = start && ((state == S_IDLE) || (state == S_HALTED));
    assign active    = (state != S_IDLE) && (state != S_HALTED);

    // Saturating performance counters; frozen while idle or halted.
    always_ff @(posedge clk) begin
        if (reset || start_acc) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (active && (cycle_cnt != CNT_MAX)) begin
                cycle_cnt <= cycle_cnt + 16'd1;
            end
            if ((state == S_DECODE) && (instr_cnt != CNT_MAX)) begin
                instr_cnt <= instr_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
